nvdla_dbb_rd_arb: RTL and testbench

//  Shares the single DBB AXI4 read port (AR + R channels) between two read clients on dla_core_clk.

---
 rtl/nvdla_dbb_rd_arb.sv | 180 ++++++++++++++++++
 tb/tb_nvdla_dbb_rd_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_dbb_rd_arb.sv
// DBB read-port arbiter: two read clients share one AXI4 AR/R port.
// Round-robin AR grant, rid[3] routes R beats, per-client burst cap.
module nvdla_dbb_rd_arb #(
    parameter int AW        = 64,
    parameter int DW        = 256,
    parameter int MAX_OUTST = 8
) (
    input  logic          dla_core_clk,
    input  logic          dla_reset_rst,
    input  logic          req0_ar_valid,
    output logic          req0_ar_ready,
    input  logic [AW-1:0] req0_ar_addr,
    input  logic [7:0]    req0_ar_len,
    input  logic [2:0]    req0_ar_tag,
    output logic          req0_r_valid,
    input  logic          req0_r_ready,
    output logic [DW-1:0] req0_r_data,
    output logic          req0_r_last,
    output logic [2:0]    req0_r_tag,
    output logic          req0_r_err,
    input  logic          req1_ar_valid,
    output logic          req1_ar_ready,
    input  logic [AW-1:0] req1_ar_addr,
    input  logic [7:0]    req1_ar_len,
    input  logic [2:0]    req1_ar_tag,
    output logic          req1_r_valid,
    input  logic          req1_r_ready,
    output logic [DW-1:0] req1_r_data,
    output logic          req1_r_last,
    output logic [2:0]    req1_r_tag,
    output logic          req1_r_err,
    output logic [3:0]    dbb_ar_arid,
    output logic [AW-1:0] dbb_ar_araddr,
    output logic [7:0]    dbb_ar_arlen,
    output logic [2:0]    dbb_ar_arsize,
    output logic [1:0]    dbb_ar_arburst,
    output logic          dbb_ar_arvalid,
    input  logic          dbb_ar_arready,
    input  logic [5:0]    dbb_r_rid,
    input  logic [DW-1:0] dbb_r_rdata,
    input  logic [1:0]    dbb_r_rresp,
    input  logic          dbb_r_rlast,
    input  logic          dbb_r_rvalid,
    output logic          dbb_r_rready,
    output logic          rd_idle
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTST);
    localparam logic [2:0] AR_SIZE = 3'($clog2(DW / 8));
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]    state;
    logic          rr_ptr;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic          elig0;
    logic          elig1;
    logic          can_grant;
    logic          gnt0;
    logic          gnt1;
    logic          r_sel;
    logic          r_done;
    logic          dec0;
    logic          dec1;
    logic          unused_r;

    assign unused_r = ^{dbb_r_rid[5:4], dbb_r_rresp[0]};

    assign elig0 = req0_ar_valid & (cnt0 < CMAX);
    assign elig1 = req1_ar_valid & (cnt1 < CMAX);

    // A held AR blocks new grants; reset masks the ready pulses.
    assign can_grant = (state == S_IDLE) & ~dla_reset_rst;

    // rr_ptr names the client preferred when both are eligible.
    assign gnt0 = can_grant & elig0 & (~elig1 | ~rr_ptr);
    assign gnt1 = can_grant & elig1 & (~elig0 | rr_ptr);

    assign req0_ar_ready = gnt0;
    assign req1_ar_ready = gnt1;

    assign r_sel        = dbb_r_rid[3];
    assign dbb_r_rready = r_sel ? req1_r_ready : req0_r_ready;
    assign req0_r_valid = dbb_r_rvalid & ~r_sel;
    assign req1_r_valid = dbb_r_rvalid & r_sel;

    assign req0_r_data = dbb_r_rdata;
    assign req1_r_data = dbb_r_rdata;
    assign req0_r_last = dbb_r_rlast;
    assign req1_r_last = dbb_r_rlast;
    assign req0_r_tag  = dbb_r_rid[2:0];
    assign req1_r_tag  = dbb_r_rid[2:0];
    assign req0_r_err  = dbb_r_rresp[1];
    assign req1_r_err  = dbb_r_rresp[1];

    assign r_done = dbb_r_rvalid & dbb_r_rready & dbb_r_rlast;
    assign dec0   = r_done & ~r_sel;
    assign dec1   = r_done & r_sel;

    assign rd_idle = (state == S_IDLE) & (cnt0 == '0) & (cnt1 == '0);

    function automatic logic [CW-1:0] cnt_nxt(
        input logic [CW-1:0] c,
        input logic          inc,
        input logic          dec
    );
        logic [CW-1:0] r;
        r = c;
        if (inc && !dec)
            r = c + 1'b1;
        else if (dec && !inc && c != '0)
            r = c - 1'b1;
        return r;
    endfunction

    // AR grant/issue FSM with registered AR fields.
    always_ff @(posedge dla_core_clk or posedge dla_reset_rst) begin
        if (dla_reset_rst) begin
            state          <= S_IDLE;
            rr_ptr         <= 1'b0;
            dbb_ar_arvalid <= 1'b0;
            dbb_ar_arid    <= '0;
            dbb_ar_araddr  <= '0;
            dbb_ar_arlen   <= '0;
            dbb_ar_arsize  <= '0;
            dbb_ar_arburst <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        state          <= S_ISSUE;
                        rr_ptr         <= gnt0;
                        dbb_ar_arvalid <= 1'b1;
                        dbb_ar_arid    <= gnt1 ? {1'b1, req1_ar_tag}
                                               : {1'b0, req0_ar_tag};
                        dbb_ar_araddr  <= gnt1 ? req1_ar_addr
                                               : req0_ar_addr;
                        dbb_ar_arlen   <= gnt1 ? req1_ar_len
                                               : req0_ar_len;
                        dbb_ar_arsize  <= AR_SIZE;
                        dbb_ar_arburst <= 2'b01;
                    end
                end
                S_ISSUE: begin
                    if (dbb_ar_arready) begin
                        state          <= S_IDLE;
                        dbb_ar_arvalid <= 1'b0;
                    end
                end
                default: begin
                    state          <= S_IDLE;
                    dbb_ar_arvalid <= 1'b0;
                end
            endcase
        end
    end

    // In-flight burst counters: up at grant, down at last R beat.
    always_ff @(posedge dla_core_clk or posedge dla_reset_rst) begin
        if (dla_reset_rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt_nxt(cnt0, gnt0, dec0);
            cnt1 <= cnt_nxt(cnt1, gnt1, dec1);
        end
    end

    // A last beat for a client with nothing in flight is a bus error.
    a_no_underflow0: assert property (
        @(posedge dla_core_clk) disable iff (dla_reset_rst)
        !(dec0 && cnt0 == '0));

    a_no_underflow1: assert property (
        @(posedge dla_core_clk) disable iff (dla_reset_rst)
        !(dec1 && cnt1 == '0));

endmodule

// File: tb/tb_nvdla_dbb_rd_arb.sv
// Randomized bench for nvdla_dbb_rd_arb against a transaction-level
// model: grant order, in-flight counts and the held AR record.
module tb_nvdla_dbb_rd_arb;

    localparam int AW = 64;
    localparam int DW = 256;
    localparam int MO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_v [2];
    logic          a_r [2];
    logic [AW-1:0] a_addr [2];
    logic [7:0]    a_len [2];
    logic [2:0]    a_tag [2];
    logic          r_v [2];
    logic          r_rdy [2];
    logic [DW-1:0] r_data [2];
    logic          r_last [2];
    logic [2:0]    r_tag [2];
    logic          r_err [2];
    logic [3:0]    arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [5:0]    rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic          rd_idle;

    always #5 clk = ~clk;

    nvdla_dbb_rd_arb #(.AW(AW), .DW(DW), .MAX_OUTST(MO)) dut (
        .dla_core_clk  (clk),
        .dla_reset_rst (rst),
        .req0_ar_valid (a_v[0]),
        .req0_ar_ready (a_r[0]),
        .req0_ar_addr  (a_addr[0]),
        .req0_ar_len   (a_len[0]),
        .req0_ar_tag   (a_tag[0]),
        .req0_r_valid  (r_v[0]),
        .req0_r_ready  (r_rdy[0]),
        .req0_r_data   (r_data[0]),
        .req0_r_last   (r_last[0]),
        .req0_r_tag    (r_tag[0]),
        .req0_r_err    (r_err[0]),
        .req1_ar_valid (a_v[1]),
        .req1_ar_ready (a_r[1]),
        .req1_ar_addr  (a_addr[1]),
        .req1_ar_len   (a_len[1]),
        .req1_ar_tag   (a_tag[1]),
        .req1_r_valid  (r_v[1]),
        .req1_r_ready  (r_rdy[1]),
        .req1_r_data   (r_data[1]),
        .req1_r_last   (r_last[1]),
        .req1_r_tag    (r_tag[1]),
        .req1_r_err    (r_err[1]),
        .dbb_ar_arid    (arid),
        .dbb_ar_araddr  (araddr),
        .dbb_ar_arlen   (arlen),
        .dbb_ar_arsize  (arsize),
        .dbb_ar_arburst (arburst),
        .dbb_ar_arvalid (arvalid),
        .dbb_ar_arready (arready),
        .dbb_r_rid      (rid),
        .dbb_r_rdata    (rdata),
        .dbb_r_rresp    (rresp),
        .dbb_r_rlast    (rlast),
        .dbb_r_rvalid   (rvalid),
        .dbb_r_rready   (rready),
        .rd_idle        (rd_idle)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          m_cnt [2];
    int          m_last;
    bit          m_busy;
    logic [3:0]  m_id;
    logic [AW-1:0] m_addr;
    logic [7:0]  m_len;
    bit          sat_seen;
    int          n_grant [2];

    task automatic model_reset();
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_last   = 1;
        m_busy   = 0;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            a_v[n]    = 1'b0;
            a_addr[n] = '0;
            a_len[n]  = '0;
            a_tag[n]  = '0;
            r_rdy[n]  = 1'b0;
        end
        arready = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        rvalid  = 1'b0;
    endtask

    // Check outputs mid-cycle, advance the model, step to next edge.
    task automatic cycle();
        bit el [2];
        int g;
        int c;
        bit exp_rr;
        @(negedge clk);
        for (int n = 0; n < 2; n++)
            el[n] = a_v[n] && (m_cnt[n] < MO);
        g = -1;
        if (!m_busy) begin
            if (el[0] && el[1]) g = 1 - m_last;
            else if (el[0])     g = 0;
            else if (el[1])     g = 1;
        end
        chk("ar_ready0", a_r[0], g == 0);
        chk("ar_ready1", a_r[1], g == 1);
        chk("arvalid", arvalid, m_busy);
        if (m_busy) begin
            chk("arid", arid, m_id);
            chk("araddr", araddr, m_addr);
            chk("arlen", arlen, m_len);
            chk("arsize", arsize, 3'd5);
            chk("arburst", arburst, 2'd1);
        end
        c = int'(rid[3]);
        exp_rr = r_rdy[c];
        chk("rready", rready, exp_rr);
        chk("r_valid0", r_v[0], rvalid && c == 0);
        chk("r_valid1", r_v[1], rvalid && c == 1);
        chk("r_data", r_data[c], rdata);
        chk("r_tag", r_tag[1 - c], rid[2:0]);
        chk("r_err", r_err[c], rresp[1]);
        chk("r_last", r_last[1 - c], rlast);
        chk("rd_idle", rd_idle,
            !m_busy && m_cnt[0] == 0 && m_cnt[1] == 0);
        if (m_busy && arready)
            m_busy = 0;
        if (g >= 0) begin
            m_busy = 1;
            m_id   = {g[0], a_tag[g]};
            m_addr = a_addr[g];
            m_len  = a_len[g];
            m_cnt[g]++;
            m_last = g;
            n_grant[g]++;
        end
        if (rvalid && exp_rr && rlast)
            m_cnt[c]--;
        if (m_cnt[0] == MO) sat_seen = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int p_av, input int p_ard,
                              input int p_rv, input int p_rrd);
        int c;
        for (int n = 0; n < 2; n++) begin
            a_v[n]    = $urandom_range(99) < p_av;
            a_addr[n] = {$urandom, $urandom};
            a_len[n]  = 8'($urandom);
            a_tag[n]  = 3'($urandom);
            r_rdy[n]  = $urandom_range(99) < p_rrd;
        end
        arready = $urandom_range(99) < p_ard;
        c = $urandom_range(1);
        rid = {2'($urandom), c[0], 3'($urandom)};
        for (int w = 0; w < DW / 32; w++)
            rdata[w*32 +: 32] = $urandom;
        rresp  = 2'($urandom);
        rvalid = $urandom_range(99) < p_rv;
        rlast  = (m_cnt[c] > 0) && ($urandom_range(1) == 1);
    endtask

    task automatic run(input int cyc, input int p_av, input int p_ard,
                       input int p_rv, input int p_rrd);
        for (int i = 0; i < cyc; i++) begin
            drive_rand(p_av, p_ard, p_rv, p_rrd);
            cycle();
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        sat_seen   = 0;
        n_grant[0] = 0;
        n_grant[1] = 0;
        rst = 1'b1;
        a_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_ready0", a_r[0], 1'b0);
        chk("rst_arid", arid, 4'h0);
        chk("rst_araddr", araddr, '0);
        chk("rst_idle", rd_idle, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        a_v[0] = 1'b0;
        @(posedge clk);
        #1;

        // Single client0 request, checked against fixed values
        a_v[0]    = 1'b1;
        a_addr[0] = 64'h1000;
        a_len[0]  = 8'd3;
        a_tag[0]  = 3'd5;
        arready   = 1'b1;
        cycle();
        a_v[0] = 1'b0;
        chk("t1_arvalid", arvalid, 1'b1);
        chk("t1_arid", arid, 4'h5);
        chk("t1_araddr", araddr, 64'h1000);
        chk("t1_arlen", arlen, 8'd3);
        chk("t1_idle", rd_idle, 1'b0);
        cycle();
        cycle();

        // Mixed traffic, stalls, saturation, slow consumers
        run(400, 60, 70, 50, 70);
        run(300, 100, 100, 0, 50);
        run(300, 90, 20, 40, 80);
        run(300, 80, 80, 70, 20);
        run(400, 50, 50, 60, 60);

        // Async reset while an AR is held
        idle_inputs();
        a_v[1] = 1'b1;
        cycle();
        a_v[1] = 1'b0;
        chk("t6_held", arvalid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_arvalid", arvalid, 1'b0);
        chk("t6_idle", rd_idle, 1'b1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run(200, 60, 60, 50, 60);

        chk("t4_sat_reached", sat_seen, 1'b1);
        chk("both_granted",
            (n_grant[0] > 50) && (n_grant[1] > 50), 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
